// File: rtl/xgmii_pkg.sv
// Shared XGMII character codes, receive FSM states and a lane-decode helper
// for the per-port status monitor.
package xgmii_pkg;

    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;
    localparam logic [7:0] XGMII_IDLE  = 8'h07;

    typedef enum logic {
        IDLE,
        IN_FRAME
    } rx_state_t;

    // True when the given lane carries control character ch with its rxc flag set.
    function automatic logic isCtrlChar(input logic [63:0] rxd, input logic [7:0] rxc,
                                        input logic [2:0] lane, input logic [7:0] ch);
        return rxc[lane] && (rxd[{lane, 3'b000} +: 8] == ch);
    endfunction

endpackage

// File: rtl/xgmii_port_status_lane.sv
// One XGMII port: block-lock debounce, frame-tracking FSM, saturating
// frame/error/link-down counters and the activity-blink LED timer.
module xgmii_port_status_lane
    import xgmii_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int HOLD_CYCLES  = 1024,
    parameter int BLINK_CYCLES = 2_000_000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic [63:0]      rxd_i,
    input  logic [7:0]       rxc_i,
    input  logic             lock_i,
    output logic             linkUp_o,
    output logic             led_o,
    output logic [CNT_W-1:0] rxFrames_o,
    output logic [CNT_W-1:0] rxErrors_o,
    output logic [CNT_W-1:0] linkDowns_o
);

    localparam int LOCK_W = $clog2(HOLD_CYCLES);
    localparam int TMR_W  = $clog2(BLINK_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(HOLD_CYCLES - 1);

    rx_state_t         state_q, state_d;
    logic [LOCK_W-1:0] lockCnt_q, lockCnt_d;
    logic              linkUp_q, linkUp_d;
    logic              led_q, led_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0]  frames_q, frames_d;
    logic [CNT_W-1:0]  errors_q, errors_d;
    logic [CNT_W-1:0]  downs_q, downs_d;

    logic [7:0] termLane, errLane;
    logic       start0, start4;
    logic       frameInc, errInc, downInc, arm;

    // Clear wins over the old value; otherwise hold at all-ones.
    function automatic logic [CNT_W-1:0] satNext(input logic [CNT_W-1:0] cur,
                                                 input logic inc, input logic clear);
        if (clear) return CNT_W'(inc);
        if (cur == '1) return cur;
        return cur + CNT_W'(inc);
    endfunction

    always_comb begin
        termLane = '0;
        errLane  = '0;
        for (int k = 0; k < 8; k++) begin
            termLane[k] = isCtrlChar(rxd_i, rxc_i, 3'(k), XGMII_TERM);
            errLane[k]  = isCtrlChar(rxd_i, rxc_i, 3'(k), XGMII_ERROR);
        end
        start0 = isCtrlChar(rxd_i, rxc_i, 3'd0, XGMII_START);
        start4 = isCtrlChar(rxd_i, rxc_i, 3'd4, XGMII_START);
    end

    always_comb begin
        lockCnt_d = lockCnt_q;
        linkUp_d  = linkUp_q;
        if (!lock_i) begin
            lockCnt_d = '0;
            linkUp_d  = 1'b0;
        end else if (lockCnt_q == LOCK_MAX) begin
            linkUp_d  = 1'b1;
        end else begin
            lockCnt_d = lockCnt_q + 1'b1;
        end
        downInc = linkUp_q && !linkUp_d;
    end

    // A Start in lane 0, or in lane 4 without a Terminate in lanes 0-3, truncates an open frame.
    always_comb begin
        state_d  = state_q;
        frameInc = 1'b0;
        errInc   = 1'b0;
        arm      = 1'b0;
        if (linkUp_q) begin
            if (start0 || start4) begin
                frameInc = 1'b1;
                arm      = 1'b1;
                state_d  = IN_FRAME;
                if (state_q == IN_FRAME && (start0 || !(|termLane[3:0]))) errInc = 1'b1;
                if (|errLane) errInc = 1'b1;
            end else if (state_q == IN_FRAME) begin
                if (|errLane) errInc = 1'b1;
                if (|termLane) state_d = IDLE;
            end
        end
        if (!linkUp_d) state_d = IDLE;
    end

    always_comb begin
        tmr_d = tmr_q;
        if (!linkUp_q)       tmr_d = '0;
        else if (arm)        tmr_d = TMR_W'(BLINK_CYCLES);
        else if (tmr_q != 0) tmr_d = tmr_q - 1'b1;
        led_d    = linkUp_d && (tmr_d == '0);
        frames_d = satNext(frames_q, frameInc, clr_i);
        errors_d = satNext(errors_q, errInc, clr_i);
        downs_d  = satNext(downs_q, downInc, clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            lockCnt_q <= '0;
            linkUp_q  <= 1'b0;
            led_q     <= 1'b0;
            tmr_q     <= '0;
            frames_q  <= '0;
            errors_q  <= '0;
            downs_q   <= '0;
        end else begin
            state_q   <= state_d;
            lockCnt_q <= lockCnt_d;
            linkUp_q  <= linkUp_d;
            led_q     <= led_d;
            tmr_q     <= tmr_d;
            frames_q  <= frames_d;
            errors_q  <= errors_d;
            downs_q   <= downs_d;
        end
    end

    assign linkUp_o    = linkUp_q;
    assign led_o       = led_q;
    assign rxFrames_o  = frames_q;
    assign rxErrors_o  = errors_q;
    assign linkDowns_o = downs_q;

endmodule

// File: rtl/xgmii_port_status.sv
// Receive status monitor for all XGMII ports; one independent lane per port,
// the top only slices the packed buses.
module xgmii_port_status
    import xgmii_pkg::*;
#(
    parameter int NPORTS       = 4,
    parameter int CNT_W        = 32,
    parameter int HOLD_CYCLES  = 1024,
    parameter int BLINK_CYCLES = 2_000_000
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    clr,
    input  logic [NPORTS*64-1:0]    xgmii_rxd,
    input  logic [NPORTS*8-1:0]     xgmii_rxc,
    input  logic [NPORTS*8-1:0]     xphy_status,
    output logic [NPORTS-1:0]       link_up,
    output logic [NPORTS-1:0]       led,
    output logic [NPORTS*CNT_W-1:0] rx_frames,
    output logic [NPORTS*CNT_W-1:0] rx_errors,
    output logic [NPORTS*CNT_W-1:0] link_downs
);

    for (genvar p = 0; p < NPORTS; p++) begin : gPort
        // Only block lock (bit 0) of each PHY status byte is meaningful here.
        logic unusedStatus;
        assign unusedStatus = ^xphy_status[p*8+1 +: 7];

        xgmii_port_status_lane #(
            .CNT_W        (CNT_W),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .BLINK_CYCLES (BLINK_CYCLES)
        ) uLane (
            .clk_i       (sys_clk),
            .rst_ni      (sys_rst_n),
            .clr_i       (clr),
            .rxd_i       (xgmii_rxd[p*64 +: 64]),
            .rxc_i       (xgmii_rxc[p*8 +: 8]),
            .lock_i      (xphy_status[p*8]),
            .linkUp_o    (link_up[p]),
            .led_o       (led[p]),
            .rxFrames_o  (rx_frames[p*CNT_W +: CNT_W]),
            .rxErrors_o  (rx_errors[p*CNT_W +: CNT_W]),
            .linkDowns_o (link_downs[p*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_xgmii_port_status.sv
// Directed-vector bench for xgmii_port_status: debounce timing, frame FSM,
// saturation/clear, per-port link loss, LED blink and async reset.
module tb_xgmii_port_status;

    localparam int NPORTS = 4;
    localparam int CNT_W  = 4;
    localparam int HOLD   = 1024;
    localparam int BLINK  = 16;

    localparam logic [63:0] IDLE_D  = {8{8'h07}};
    localparam logic [7:0]  IDLE_C  = 8'hFF;
    localparam logic [63:0] START0  = 64'hD5555555555555FB;
    localparam logic [7:0]  START0C = 8'h01;
    localparam logic [63:0] START4  = 64'hD55555FB07070707;
    localparam logic [7:0]  START4C = 8'h1F;
    localparam logic [63:0] DATA_D  = 64'h0123456789ABCDEF;
    localparam logic [63:0] TERM3   = 64'h07070707FDAABBCC;
    localparam logic [7:0]  TERM3C  = 8'hF8;
    localparam logic [63:0] T2S4    = 64'h555555FB07FD1122;
    localparam logic [7:0]  T2S4C   = 8'h1C;
    localparam logic [63:0] ERRW    = 64'h44332211FE334455;
    localparam logic [7:0]  ERRWC   = 8'h08;
    localparam logic [63:0] S0ERR   = 64'h5555FE55555555FB;
    localparam logic [7:0]  S0ERRC  = 8'h21;

    logic                    sysClk;
    logic                    sysRstN;
    logic                    clr;
    logic [NPORTS*64-1:0]    rxd;
    logic [NPORTS*8-1:0]     rxc;
    logic [NPORTS*8-1:0]     phyStatus;
    logic [NPORTS-1:0]       linkUp;
    logic [NPORTS-1:0]       led;
    logic [NPORTS*CNT_W-1:0] rxFrames;
    logic [NPORTS*CNT_W-1:0] rxErrors;
    logic [NPORTS*CNT_W-1:0] linkDowns;

    int checks;
    int failures;

    xgmii_port_status #(
        .NPORTS       (NPORTS),
        .CNT_W        (CNT_W),
        .HOLD_CYCLES  (HOLD),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .sys_clk     (sysClk),
        .sys_rst_n   (sysRstN),
        .clr         (clr),
        .xgmii_rxd   (rxd),
        .xgmii_rxc   (rxc),
        .xphy_status (phyStatus),
        .link_up     (linkUp),
        .led         (led),
        .rx_frames   (rxFrames),
        .rx_errors   (rxErrors),
        .link_downs  (linkDowns)
    );

    // 156.25 MHz is irrelevant to behaviour; a 10-unit period keeps the math simple.
    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    // Compares one observation against its hand-computed value and records the outcome.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one word on port p for exactly one clock, then returns the port to idle.
    task automatic applyStimulus(input int p, input logic [63:0] d, input logic [7:0] c);
        rxd[p*64 +: 64] = d;
        rxc[p*8 +: 8]   = c;
        @(posedge sysClk);
        @(negedge sysClk);
        rxd[p*64 +: 64] = IDLE_D;
        rxc[p*8 +: 8]   = IDLE_C;
    endtask

    task automatic runIdle(input int n);
        repeat (n) begin
            @(posedge sysClk);
            @(negedge sysClk);
        end
    endtask

    // Drives every stage of the directed plan; each check uses values worked out by hand.
    initial begin
        checks    = 0;
        failures  = 0;
        sysRstN   = 1'b0;
        clr       = 1'b0;
        rxd       = {NPORTS{IDLE_D}};
        rxc       = {NPORTS{IDLE_C}};
        phyStatus = '0;

        #7;
        checkOutput("rst_link_up", 32'(linkUp), 32'h0);
        checkOutput("rst_led", 32'(led), 32'h0);
        checkOutput("rst_frames", 32'(rxFrames), 32'h0);
        checkOutput("rst_errors", 32'(rxErrors), 32'h0);
        checkOutput("rst_downs", 32'(linkDowns), 32'h0);

        @(negedge sysClk);
        sysRstN   = 1'b1;
        phyStatus = {NPORTS{8'h01}};
        runIdle(HOLD - 1);
        checkOutput("link_before_hold", 32'(linkUp), 32'h0);
        runIdle(1);
        checkOutput("link_at_hold", 32'(linkUp), 32'hF);
        checkOutput("led_link_idle", 32'(led), 32'hF);

        $display("[TB] port 0 basic frame and blink");
        applyStimulus(0, START0, START0C);
        checkOutput("p0_frames_start", 32'(rxFrames[0 +: CNT_W]), 32'd1);
        checkOutput("p0_led_armed", 32'(led[0]), 32'd0);
        for (int i = 0; i < 8; i++) applyStimulus(0, DATA_D, 8'h00);
        applyStimulus(0, TERM3, TERM3C);
        checkOutput("p0_frames_end", 32'(rxFrames[0 +: CNT_W]), 32'd1);
        checkOutput("p0_errors_end", 32'(rxErrors[0 +: CNT_W]), 32'd0);
        runIdle(6);
        checkOutput("p0_led_last_low", 32'(led[0]), 32'd0);
        runIdle(1);
        checkOutput("p0_led_back_high", 32'(led[0]), 32'd1);

        $display("[TB] port 1 truncation, back-to-back and error chars");
        applyStimulus(1, START0, START0C);
        applyStimulus(1, START0, START0C);
        checkOutput("p1_frames_trunc", 32'(rxFrames[CNT_W +: CNT_W]), 32'd2);
        checkOutput("p1_errors_trunc", 32'(rxErrors[CNT_W +: CNT_W]), 32'd1);
        applyStimulus(1, T2S4, T2S4C);
        checkOutput("p1_frames_b2b", 32'(rxFrames[CNT_W +: CNT_W]), 32'd3);
        checkOutput("p1_errors_b2b", 32'(rxErrors[CNT_W +: CNT_W]), 32'd1);
        applyStimulus(1, TERM3, TERM3C);
        applyStimulus(1, START4, START4C);
        applyStimulus(1, ERRW, ERRWC);
        checkOutput("p1_errors_inframe", 32'(rxErrors[CNT_W +: CNT_W]), 32'd2);
        applyStimulus(1, S0ERR, S0ERRC);
        checkOutput("p1_frames_truncerr", 32'(rxFrames[CNT_W +: CNT_W]), 32'd5);
        checkOutput("p1_errors_truncerr", 32'(rxErrors[CNT_W +: CNT_W]), 32'd3);
        applyStimulus(1, TERM3, TERM3C);
        applyStimulus(1, ERRW, ERRWC);
        applyStimulus(1, TERM3, TERM3C);
        checkOutput("p1_errors_idle", 32'(rxErrors[CNT_W +: CNT_W]), 32'd3);

        $display("[TB] port 3 saturation and clear");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(3, START0, START0C);
            applyStimulus(3, TERM3, TERM3C);
        end
        checkOutput("p3_frames_sat", 32'(rxFrames[3*CNT_W +: CNT_W]), 32'd15);
        clr = 1'b1;
        applyStimulus(3, START0, START0C);
        clr = 1'b0;
        checkOutput("p3_frames_clr", 32'(rxFrames[3*CNT_W +: CNT_W]), 32'd1);
        checkOutput("all_errors_clr", 32'(rxErrors), 32'h0);
        checkOutput("p1_frames_clr", 32'(rxFrames[CNT_W +: CNT_W]), 32'd0);
        applyStimulus(3, TERM3, TERM3C);

        $display("[TB] port 2 lock loss mid-frame");
        applyStimulus(2, START0, START0C);
        checkOutput("p2_frames_start", 32'(rxFrames[2*CNT_W +: CNT_W]), 32'd1);
        phyStatus[16] = 1'b0;
        runIdle(1);
        checkOutput("p2_link_drop", 32'(linkUp), 32'hB);
        checkOutput("p2_downs", 32'(linkDowns), 32'h0100);
        applyStimulus(2, TERM3, TERM3C);
        checkOutput("p2_frames_hold", 32'(rxFrames[2*CNT_W +: CNT_W]), 32'd1);
        phyStatus[16] = 1'b1;
        runIdle(HOLD);
        checkOutput("p2_relink", 32'(linkUp), 32'hF);
        checkOutput("led_all_settled", 32'(led), 32'hF);
        applyStimulus(2, ERRW, ERRWC);
        checkOutput("p2_fsm_idle", 32'(rxErrors[2*CNT_W +: CNT_W]), 32'd0);

        $display("[TB] async reset mid-frame");
        applyStimulus(0, START0, START0C);
        checkOutput("p0_frames_prerst", 32'(rxFrames[0 +: CNT_W]), 32'd1);
        #2 sysRstN = 1'b0;
        #1;
        checkOutput("arst_link_up", 32'(linkUp), 32'h0);
        checkOutput("arst_led", 32'(led), 32'h0);
        checkOutput("arst_frames", 32'(rxFrames), 32'h0);
        checkOutput("arst_downs", 32'(linkDowns), 32'h0);
        @(negedge sysClk);
        sysRstN = 1'b1;
        runIdle(HOLD);
        checkOutput("arst_relink", 32'(linkUp), 32'hF);
        applyStimulus(0, START0, START0C);
        checkOutput("arst_frames_first", 32'(rxFrames[0 +: CNT_W]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xgmii_port_status.md
# xgmii_port_status

Parametrised per-port receive status monitor for the XGMII side of the 10GBASE-R network paths. Each port has:
- a debounced link indicator derived from PHY block lock;
- a frame-tracking state machine on the 64-bit XGMII RX word;
- saturating frame and error counters;
- an activity-blinking LED drive.

It replaces the fixed per-port `status[0]`-to-LED wiring in the board top. It sits in the `clk156` domain, one instance covering all ports.

## Interface
- `NPORTS`, 4: number of XGMII ports monitored (1..8).
- `CNT_W`, 32: width of each per-port counter.
- `HOLD_CYCLES`, 1024: consecutive block-lock cycles required before link is declared up (≥2).
- `BLINK_CYCLES`, 2_000_000: LED-off duration after frame activity (≥1).
- `sys_clk` in 1: 156.25 MHz XGMII clock.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous clear of all counters, all ports.
- `xgmii_rxd` in NPORTS*64: RX data; port p at `[p*64 +: 64]`, lane k at bits `[8k +: 8]`.
- `xgmii_rxc` in NPORTS*8: RX control flags; port p at `[p*8 +: 8]`.
- `xphy_status` in NPORTS*8: PHY status; bit 0 of each byte is block lock.
- `link_up` out NPORTS: debounced link state.
- `led` out NPORTS: LED drive.
- `rx_frames` out NPORTS*CNT_W: frame start count.
- `rx_errors` out NPORTS*CNT_W: error event count.
- `link_downs` out NPORTS*CNT_W: count of `link_up` falling edges.

## Operation
- **Control characters:** recognised only when the corresponding `rxc` bit is 1.
  - Start: 0xFB, valid in lane 0 or lane 4 only.
  - Terminate: 0xFD, any lane.
  - Error: 0xFE, any lane.
- **Debounce:**
  - Per-port counter increments while block lock is 1.
  - `link_up` asserts when the counter reaches `HOLD_CYCLES-1` with lock still 1.
  - Block lock 0 clears the counter and drops `link_up` on the next edge.
  - A `link_up` 1→0 transition increments `link_downs`.
- **Frame FSM, states IDLE and IN_FRAME, evaluated only while `link_up`=1:**
  - IDLE + Start → IN_FRAME, `rx_frames`++.
  - IN_FRAME + Terminate → IDLE.
  - IN_FRAME + Start with no preceding Terminate in the same word → `rx_frames`++ and `rx_errors`++ (truncated frame); state stays IN_FRAME.
  - Terminate in lanes 0-3 plus Start in lane 4 of the same word → frame ends and the next begins: `rx_frames`++, state IN_FRAME, no error.
  - Error character anywhere in the word while IN_FRAME, or in the Start word → `rx_errors`++. Increment is at most 1 per word, including when combined with a truncation.
  - Terminate while IDLE is ignored.
- **Link down:** FSM forced to IDLE; frame and error counters hold; RX words are ignored.
- **Counters:**
  - Saturate at all-ones; never wrap.
  - `clr` has priority: a counter loads the same-cycle increment value (0 or 1) rather than old+inc.
- **LED:**
  - `led` = `link_up` AND NOT `blink_active`.
  - Each Start arms a blink timer for `BLINK_CYCLES` cycles. A re-arm during an active blink restarts the timer.
  - Timer is cleared when `link_up`=0.
- Ports are fully independent; no cross-port arbitration.

## Timing
- All outputs registered. Reset values: `link_up`, `led`, and all counters = 0; FSMs IDLE; timers 0.
- Input word at edge N updates FSM and counters visible after edge N+1 (latency 1).
- Block lock rising at edge N, held → `link_up`=1 after edge N+HOLD_CYCLES.
- Block lock falling at edge N → `link_up`=0 after edge N+1, `link_downs` updated on the same edge.
- `clr` at edge N → counters reflect the clear after edge N+1.
- Reset assertion mid-frame immediately zeroes all state asynchronously. Deassertion is used as synchronised externally; the first post-reset word is processed normally.

## Structure
- Package `xgmii_pkg`:
  - constants `XGMII_START`=8'hFB, `XGMII_TERM`=8'hFD, `XGMII_ERROR`=8'hFE, `XGMII_IDLE`=8'h07;
  - `rx_state_t` enum {IDLE, IN_FRAME}.
- Sub-module `xgmii_port_status_lane`: one port (debounce, FSM, three counters, blink timer). Generated NPORTS times in the top; the top only slices buses.

## Test plan
- Lock rises, held 1024 cycles, then one lane-0 Start, 8 data words, Terminate in lane 3 → `link_up` asserts exactly at cycle 1024; `rx_frames`=1, `rx_errors`=0; `led` low for `BLINK_CYCLES` (set to 16 in bench), then high.
- Start, then Start again with no Terminate → `rx_frames`=2, `rx_errors`=1; one word holding Terminate lane 2 + Start lane 4 → `rx_frames`=3, errors unchanged.
- Error char inside frame, plus an error char in a truncating Start word → `rx_errors` increments by exactly 1 per word.
- `CNT_W`=4, 20 frames → `rx_frames`=15 (saturated); `clr` in the same cycle as a Start → `rx_frames`=1.
- Lock drops mid-frame on port 2 only → port 2 `link_up`=0 and `link_downs`=1 next cycle; FSM IDLE; subsequent Terminate ignored; ports 0,1,3 unaffected.
- `sys_rst_n` pulsed low mid-frame → all outputs 0 immediately; the first Start after relock counts from 1.
